// File: rtl/hsv_div_scheduler_if.sv
// Pixel-side and result-side handshake bundle for the RGB->HSV scheduler.
// The slave modport is the converter's view; master is the pixel source / result sink view.
interface hsv_div_scheduler_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_h;
    logic [7:0] out_s;
    logic [7:0] out_v;
    logic       busy;

    modport slave (
        input  in_valid, in_r, in_g, in_b, out_ready,
        output in_ready, out_valid, out_h, out_s, out_v, busy
    );

    modport master (
        output in_valid, in_r, in_g, in_b, out_ready,
        input  in_ready, out_valid, out_h, out_s, out_v, busy
    );
endinterface

// File: rtl/hsv_div_scheduler.sv
// Pixel-serial RGB->HSV converter; one restoring divider is shared between the hue
// quotient and the saturation quotient, sequenced by a small FSM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a pixel, in_ready high
// HUE_DIV | dividing |diff|*HUE_SCALE by delta, one quotient bit per cycle
// SAT_DIV | dividing 255*delta by max, one quotient bit per cycle
// DONE    | result presented, waiting for out_ready
module hsv_div_scheduler #(
    parameter int DIV_BITS  = 16,
    parameter int HUE_SCALE = 43
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hsv_div_scheduler_if.slave    bus
);

    localparam int            CW       = $clog2(DIV_BITS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_BITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUE_DIV = 2'd1,
        SAT_DIV = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DIV_BITS-1:0] quo;
    logic [7:0]          rem;
    logic [7:0]          dvs;
    logic [7:0]          max_q;
    logic [7:0]          off_q;
    logic                neg_q;
    logic [7:0]          hue_q;

    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [7:0]          out_h_q;
    logic [7:0]          out_s_q;
    logic [7:0]          out_v_q;

    logic [7:0]          max_c;
    logic [7:0]          min_c;
    logic [7:0]          delta_c;
    logic [7:0]          off_c;
    logic [8:0]          diff_c;
    logic [7:0]          abs_c;
    logic [DIV_BITS-1:0] hue_dvd;
    logic [DIV_BITS-1:0] sat_dvd;
    logic [8:0]          rem_sh;
    logic                take;
    logic [7:0]          rem_nx;
    logic [DIV_BITS-1:0] quo_nx;
    logic [7:0]          hue_c;

    // Max selection uses strict compares so ties resolve R, then G, then B.
    always_comb begin
        max_c  = bus.in_r;
        off_c  = 8'd0;
        diff_c = {1'b0, bus.in_g} - {1'b0, bus.in_b};
        if (bus.in_g > max_c) begin
            max_c  = bus.in_g;
            off_c  = 8'd85;
            diff_c = {1'b0, bus.in_b} - {1'b0, bus.in_r};
        end
        if (bus.in_b > max_c) begin
            max_c  = bus.in_b;
            off_c  = 8'd171;
            diff_c = {1'b0, bus.in_r} - {1'b0, bus.in_g};
        end

        min_c = bus.in_r;
        if (bus.in_g < min_c) min_c = bus.in_g;
        if (bus.in_b < min_c) min_c = bus.in_b;
        delta_c = max_c - min_c;

        abs_c   = diff_c[8] ? 8'(-diff_c) : diff_c[7:0];
        hue_dvd = DIV_BITS'(abs_c) * DIV_BITS'(HUE_SCALE);
        // During HUE_DIV the divisor register still holds delta.
        sat_dvd = DIV_BITS'(dvs) * DIV_BITS'(255);

        // Remainder stays below the 8-bit divisor, so 9 bits suffice for the trial.
        rem_sh = {rem, quo[DIV_BITS-1]};
        take   = (rem_sh >= {1'b0, dvs});
        rem_nx = take ? 8'(rem_sh - {1'b0, dvs}) : rem_sh[7:0];
        quo_nx = {quo[DIV_BITS-2:0], take};

        hue_c = neg_q ? (off_q - quo_nx[7:0]) : (off_q + quo_nx[7:0]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            max_q       <= '0;
            off_q       <= '0;
            neg_q       <= 1'b0;
            hue_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_h_q     <= '0;
            out_s_q     <= '0;
            out_v_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        max_q      <= max_c;
                        off_q      <= off_c;
                        neg_q      <= diff_c[8];
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (delta_c == 8'd0) begin
                            out_h_q     <= 8'd0;
                            out_s_q     <= 8'd0;
                            out_v_q     <= max_c;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            quo   <= hue_dvd;
                            rem   <= '0;
                            dvs   <= delta_c;
                            cnt   <= CNT_LOAD;
                            state <= HUE_DIV;
                        end
                    end
                end

                HUE_DIV: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        hue_q <= hue_c;
                        quo   <= sat_dvd;
                        rem   <= '0;
                        dvs   <= max_q;
                        cnt   <= CNT_LOAD;
                        state <= SAT_DIV;
                    end
                end

                SAT_DIV: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        out_h_q     <= hue_q;
                        out_s_q     <= quo_nx[7:0];
                        out_v_q     <= max_q;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_h     = out_h_q;
    assign bus.out_s     = out_s_q;
    assign bus.out_v     = out_v_q;

endmodule

// File: tb/tb_hsv_div_scheduler.sv
// Directed bench for hsv_div_scheduler: hand-computed HSV vectors, latency,
// output back-pressure, tie priority and mid-division reset abort.
module tb_hsv_div_scheduler;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hsv_div_scheduler_if bif();

    hsv_div_scheduler #(
        .DIV_BITS (16),
        .HUE_SCALE(43)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r, g, b, h, s, v;
    } vec_t;

    // Presents a pixel, waits for its accept edge, then counts edges after the
    // accept edge until out_valid is seen (0 means visible straight after accept).
    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, output int lat);
        int n;
        @(negedge clk);
        bif.in_r     = r;
        bif.in_g     = g;
        bif.in_b     = b;
        bif.in_valid = 1'b1;
        n = 0;
        while (!bif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bif.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_result();
        @(negedge clk);
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1 bif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bif.in_ready); end
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bif.out_valid); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bif.busy); end
        checks++; if ({bif.out_h, bif.out_s, bif.out_v} !== 24'h0) begin errors++; $display("FAIL reset_hsv got %0d/%0d/%0d want 0/0/0", bif.out_h, bif.out_s, bif.out_v); end
        reset_n = 1'b1;
    endtask

    task automatic test_chromatic();
        vec_t vt [8];
        int   lat;
        vt[0] = {8'd255, 8'd0,   8'd0,   8'd0,   8'd255, 8'd255};
        vt[1] = {8'd0,   8'd255, 8'd0,   8'd85,  8'd255, 8'd255};
        vt[2] = {8'd255, 8'd0,   8'd128, 8'd235, 8'd255, 8'd255};
        vt[3] = {8'd200, 8'd100, 8'd50,  8'd14,  8'd191, 8'd200};
        vt[4] = {8'd0,   8'd0,   8'd255, 8'd171, 8'd255, 8'd255};
        vt[5] = {8'd10,  8'd20,  8'd30,  8'd150, 8'd170, 8'd30};
        vt[6] = {8'd255, 8'd255, 8'd0,   8'd43,  8'd255, 8'd255};
        vt[7] = {8'd50,  8'd100, 8'd200, 8'd157, 8'd191, 8'd200};
        for (int i = 0; i < 8; i++) begin
            send_pixel(vt[i].r, vt[i].g, vt[i].b, lat);
            checks++; if (lat !== 32) begin errors++; $display("FAIL chrom_latency[%0d] got %0d want 32", i, lat); end
            checks++; if (bif.out_h !== vt[i].h) begin errors++; $display("FAIL chrom_h[%0d] got %0d want %0d", i, bif.out_h, vt[i].h); end
            checks++; if (bif.out_s !== vt[i].s) begin errors++; $display("FAIL chrom_s[%0d] got %0d want %0d", i, bif.out_s, vt[i].s); end
            checks++; if (bif.out_v !== vt[i].v) begin errors++; $display("FAIL chrom_v[%0d] got %0d want %0d", i, bif.out_v, vt[i].v); end
            checks++; if ({bif.in_ready, bif.busy} !== 2'b01) begin errors++; $display("FAIL chrom_done_flags[%0d] got ready=%0b busy=%0b want 0/1", i, bif.in_ready, bif.busy); end
            pop_result();
        end
    endtask

    task automatic test_achromatic();
        logic [7:0] lv [3];
        int lat;
        lv[0] = 8'd100;
        lv[1] = 8'd255;
        lv[2] = 8'd0;
        for (int i = 0; i < 3; i++) begin
            send_pixel(lv[i], lv[i], lv[i], lat);
            checks++; if (lat !== 0) begin errors++; $display("FAIL achrom_latency[%0d] got %0d want 0 extra edges", i, lat); end
            checks++; if ({bif.out_h, bif.out_s} !== 16'h0) begin errors++; $display("FAIL achrom_hs[%0d] got %0d/%0d want 0/0", i, bif.out_h, bif.out_s); end
            checks++; if (bif.out_v !== lv[i]) begin errors++; $display("FAIL achrom_v[%0d] got %0d want %0d", i, bif.out_v, lv[i]); end
            pop_result();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        send_pixel(8'd10, 8'd20, 8'd30, lat);
        checks++; if ({bif.out_h, bif.out_s, bif.out_v} !== {8'd150, 8'd170, 8'd30}) begin errors++; $display("FAIL bp_first got %0d/%0d/%0d want 150/170/30", bif.out_h, bif.out_s, bif.out_v); end
        // Next pixel waits on the bus while the result is held; it must not be taken early.
        bif.in_r = 8'd255; bif.in_g = 8'd255; bif.in_b = 8'd0; bif.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bif.out_valid, bif.in_ready, bif.busy, bif.out_h, bif.out_s, bif.out_v}
                !== {1'b1, 1'b0, 1'b1, 8'd150, 8'd170, 8'd30}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%0b r=%0b b=%0b %0d/%0d/%0d want 1/0/1 150/170/30",
                         i, bif.out_valid, bif.in_ready, bif.busy, bif.out_h, bif.out_s, bif.out_v);
            end
        end
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1 bif.out_ready = 1'b0;
        @(negedge clk);
        checks++; if ({bif.out_valid, bif.in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got valid=%0b ready=%0b want 0/1", bif.out_valid, bif.in_ready); end
        checks++; if (bif.out_h !== 8'd150) begin errors++; $display("FAIL bp_keep_h got %0d want 150", bif.out_h); end
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bif.in_ready, bif.busy} !== 2'b01) begin errors++; $display("FAIL bp_next_accept got ready=%0b busy=%0b want 0/1", bif.in_ready, bif.busy); end
        lat = 0;
        while (!bif.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL bp_next_latency got %0d want 32", lat); end
        checks++; if ({bif.out_h, bif.out_s, bif.out_v} !== {8'd43, 8'd255, 8'd255}) begin errors++; $display("FAIL bp_next_hsv got %0d/%0d/%0d want 43/255/255", bif.out_h, bif.out_s, bif.out_v); end
        pop_result();
    endtask

    task automatic test_reset_abort();
        int  lat;
        logic seen;
        @(negedge clk);
        bif.in_r = 8'd200; bif.in_g = 8'd100; bif.in_b = 8'd50; bif.in_valid = 1'b1;
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %0b want 1", bif.busy); end
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if ({bif.out_valid, bif.in_ready, bif.busy} !== 3'b010) begin errors++; $display("FAIL abort_flags got valid=%0b ready=%0b busy=%0b want 0/1/0", bif.out_valid, bif.in_ready, bif.busy); end
        checks++; if ({bif.out_h, bif.out_s, bif.out_v} !== 24'h0) begin errors++; $display("FAIL abort_hsv got %0d/%0d/%0d want 0/0/0", bif.out_h, bif.out_s, bif.out_v); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bif.out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_emit got %0b want 0", seen); end
        send_pixel(8'd0, 8'd0, 8'd255, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL abort_after_latency got %0d want 32", lat); end
        checks++; if ({bif.out_h, bif.out_s, bif.out_v} !== {8'd171, 8'd255, 8'd255}) begin errors++; $display("FAIL abort_after_hsv got %0d/%0d/%0d want 171/255/255", bif.out_h, bif.out_s, bif.out_v); end
        pop_result();
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_r      = 8'd0;
        bif.in_g      = 8'd0;
        bif.in_b      = 8'd0;
        bif.out_ready = 1'b0;
        test_reset();
        test_chromatic();
        test_achromatic();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
